// File: rtl/jtframe_upld_pkg.sv
// Shared types and defaults for the SDRAM upload (read-back) path.
package jtframe_upld_pkg;

  localparam int unsigned AW  = 26;  // host byte address width
  localparam int unsigned WW  = 22;  // SDRAM word address width within a bank
  localparam int unsigned BAW = 2;   // bank select width
  localparam int unsigned DW  = 16;  // SDRAM data width
  localparam int unsigned BYW = 8;   // host byte width
  localparam int unsigned TW  = 8;   // timeout counter width

  localparam logic [24:0] BA1_DEF = 25'h040_0000;
  localparam logic [24:0] BA2_DEF = 25'h080_0000;
  localparam logic [24:0] BA3_DEF = 25'h0C0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2
  } upld_st_e;

  // Buffer tag: which SDRAM word is held.
  typedef struct packed {
    logic [BAW-1:0] ba;
    logic [WW-1:0]  waddr;
  } tag_t;

  // Decoded host address.
  typedef struct packed {
    logic [BAW-1:0] ba;
    logic [WW-1:0]  waddr;
    logic           sel;   // 0: data[7:0], 1: data[15:8]
    logic           oor;   // beyond the end of its bank
  } bmap_t;

  function automatic logic [BYW-1:0] byte_pick(input logic [DW-1:0] w, input logic sel);
    return sel ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/jtframe_upld_if.sv
// Host ioctl upload port plus SDRAM programming-port read signals.
interface jtframe_upld_if;
  import jtframe_upld_pkg::*;

  logic           ioctl_ram;
  logic [AW-1:0]  ioctl_addr;
  logic           ioctl_rd;
  logic [BYW-1:0] ioctl_din;
  logic           ioctl_rdy;
  logic [WW-1:0]  prog_addr;
  logic [BAW-1:0] prog_ba;
  logic           prog_rd;
  logic [1:0]     prog_dsn;
  logic [DW-1:0]  prog_data;
  logic           prog_dok;
  logic           prog_rdy;

  modport master (
    input  ioctl_ram, ioctl_addr, ioctl_rd, prog_data, prog_dok, prog_rdy,
    output ioctl_din, ioctl_rdy, prog_addr, prog_ba, prog_rd, prog_dsn
  );

  modport slave (
    output ioctl_ram, ioctl_addr, ioctl_rd, prog_data, prog_dok, prog_rdy,
    input  ioctl_din, ioctl_rdy, prog_addr, prog_ba, prog_rd, prog_dsn
  );
endinterface

// File: rtl/jtframe_upld_bankmap.sv
// Byte address to {bank, word address, byte lane, out-of-range} decode.
module jtframe_upld_bankmap
  import jtframe_upld_pkg::*;
#(
  parameter logic [24:0] BA1_START = BA1_DEF,
  parameter logic [24:0] BA2_START = BA2_DEF,
  parameter logic [24:0] BA3_START = BA3_DEF,
  parameter bit          SWAB      = 1'b0
) (
  input  logic [AW-1:0] addr,
  output bmap_t         map_c
);

  logic [AW-1:0] base;
  logic [AW-1:0] off;

  // Pick the highest bank whose start is not above the address.
  always_comb begin
    map_c = '0;
    if (addr >= AW'(BA3_START)) begin
      map_c.ba = 2'd3;
      base     = AW'(BA3_START);
    end else if (addr >= AW'(BA2_START)) begin
      map_c.ba = 2'd2;
      base     = AW'(BA2_START);
    end else if (addr >= AW'(BA1_START)) begin
      map_c.ba = 2'd1;
      base     = AW'(BA1_START);
    end else begin
      map_c.ba = 2'd0;
      base     = '0;
    end
    off         = addr - base;
    map_c.waddr = off[22:1];
    map_c.sel   = off[0] ^ SWAB;
    map_c.oor   = |off[25:23];
  end

endmodule

// File: rtl/jtframe_upld.sv
// Host byte upload -> 16-bit SDRAM reads with a one-word buffer.
module jtframe_upld
  import jtframe_upld_pkg::*;
#(
  parameter logic [24:0] BA1_START = BA1_DEF,
  parameter logic [24:0] BA2_START = BA2_DEF,
  parameter logic [24:0] BA3_START = BA3_DEF,
  parameter bit          SWAB      = 1'b0,
  parameter int unsigned TOUT      = 255
) (
  input  logic         clk,
  input  logic         rst,
  jtframe_upld_if.master bus,
  output logic         busy,
  output logic         err
);

  upld_st_e       st, st_nxt;
  bmap_t          map_c;
  logic [DW-1:0]  buf_data, buf_data_nxt;
  tag_t           buf_tag, buf_tag_nxt;
  logic           buf_vld, buf_vld_nxt;
  tag_t           pend_tag, pend_tag_nxt;
  logic           pend_sel, pend_sel_nxt;
  logic           pend_drop, pend_drop_nxt;
  logic [TW-1:0]  cnt, cnt_nxt;
  logic           ram_l;
  logic           ram_rise, hit;
  logic [DW-1:0]  word_now;
  logic           prog_rd_nxt, ioctl_rdy_nxt, busy_nxt, err_nxt;
  logic [WW-1:0]  prog_addr_nxt;
  logic [BAW-1:0] prog_ba_nxt;
  logic [BYW-1:0] ioctl_din_nxt;

  jtframe_upld_bankmap #(
    .BA1_START(BA1_START), .BA2_START(BA2_START), .BA3_START(BA3_START), .SWAB(SWAB)
  ) u_bankmap (
    .addr  (bus.ioctl_addr),
    .map_c (map_c)
  );

  assign bus.prog_dsn = 2'b00;

  // State, buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= ST_IDLE;
      buf_data      <= '0;
      buf_tag       <= '0;
      buf_vld       <= 1'b0;
      pend_tag      <= '0;
      pend_sel      <= 1'b0;
      pend_drop     <= 1'b0;
      cnt           <= '0;
      ram_l         <= 1'b0;
      bus.prog_rd   <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_ba   <= '0;
      bus.ioctl_rdy <= 1'b0;
      bus.ioctl_din <= 8'h00;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      st            <= st_nxt;
      buf_data      <= buf_data_nxt;
      buf_tag       <= buf_tag_nxt;
      buf_vld       <= buf_vld_nxt;
      pend_tag      <= pend_tag_nxt;
      pend_sel      <= pend_sel_nxt;
      pend_drop     <= pend_drop_nxt;
      cnt           <= cnt_nxt;
      ram_l         <= bus.ioctl_ram;
      bus.prog_rd   <= prog_rd_nxt;
      bus.prog_addr <= prog_addr_nxt;
      bus.prog_ba   <= prog_ba_nxt;
      bus.ioctl_rdy <= ioctl_rdy_nxt;
      bus.ioctl_din <= ioctl_din_nxt;
      busy          <= busy_nxt;
      err           <= err_nxt;
    end
  end

  // Next state, buffer update and output values.
  always_comb begin
    st_nxt        = st;
    buf_data_nxt  = buf_data;
    buf_tag_nxt   = buf_tag;
    buf_vld_nxt   = buf_vld;
    pend_tag_nxt  = pend_tag;
    pend_sel_nxt  = pend_sel;
    pend_drop_nxt = pend_drop;
    cnt_nxt       = cnt;
    prog_rd_nxt   = bus.prog_rd;
    prog_addr_nxt = bus.prog_addr;
    prog_ba_nxt   = bus.prog_ba;
    ioctl_rdy_nxt = 1'b0;
    ioctl_din_nxt = bus.ioctl_din;
    busy_nxt      = 1'b0;
    err_nxt       = err;

    ram_rise = bus.ioctl_ram & ~ram_l;
    hit      = buf_vld & ~ram_rise & (buf_tag == {map_c.ba, map_c.waddr});
    word_now = bus.prog_dok ? bus.prog_data : buf_data;

    // A new session starts with a clean buffer and no error.
    if (ram_rise) begin
      buf_vld_nxt = 1'b0;
      err_nxt     = 1'b0;
    end

    case (st)
      ST_IDLE, ST_OUT: begin
        st_nxt = ST_IDLE;
        if (bus.ioctl_rd && bus.ioctl_ram) begin
          if (map_c.oor) begin
            ioctl_rdy_nxt = 1'b1;
            ioctl_din_nxt = 8'hFF;
          end else if (hit) begin
            ioctl_rdy_nxt = 1'b1;
            ioctl_din_nxt = byte_pick(buf_data, map_c.sel);
          end else begin
            st_nxt        = ST_READ;
            prog_rd_nxt   = 1'b1;
            prog_addr_nxt = map_c.waddr;
            prog_ba_nxt   = map_c.ba;
            pend_tag_nxt  = {map_c.ba, map_c.waddr};
            pend_sel_nxt  = map_c.sel;
            pend_drop_nxt = 1'b0;
            cnt_nxt       = '0;
            busy_nxt      = 1'b1;
          end
        end
      end
      ST_READ: begin
        busy_nxt = 1'b1;
        if (bus.ioctl_rd) err_nxt = 1'b1;
        if (!bus.ioctl_ram) pend_drop_nxt = 1'b1;
        if (bus.prog_dok) buf_data_nxt = bus.prog_data;
        if (bus.prog_rdy) begin
          prog_rd_nxt = 1'b0;
          busy_nxt    = 1'b0;
          if (pend_drop || !bus.ioctl_ram) begin
            st_nxt      = ST_IDLE;
            buf_vld_nxt = 1'b0;
          end else begin
            st_nxt        = ST_OUT;
            buf_vld_nxt   = 1'b1;
            buf_tag_nxt   = pend_tag;
            ioctl_rdy_nxt = 1'b1;
            ioctl_din_nxt = byte_pick(word_now, pend_sel);
          end
        end else if (cnt == TW'(TOUT - 1)) begin
          // SDRAM never answered: give up and report 8'hFF.
          prog_rd_nxt = 1'b0;
          busy_nxt    = 1'b0;
          err_nxt     = 1'b1;
          buf_vld_nxt = 1'b0;
          if (pend_drop || !bus.ioctl_ram) begin
            st_nxt = ST_IDLE;
          end else begin
            st_nxt        = ST_OUT;
            ioctl_rdy_nxt = 1'b1;
            ioctl_din_nxt = 8'hFF;
          end
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtframe_upld.sv
// Directed bench for jtframe_upld with a fixed-latency SDRAM model.
module tb_jtframe_upld;

  localparam int LAT = 4;  // prog_rd rise to prog_rdy, in cycles

  logic clk = 1'b0;
  logic rst;
  logic busy, err;
  logic sd_en;
  int   sd_cnt;
  int   checks = 0;
  int   errors = 0;

  jtframe_upld_if bus();

  jtframe_upld dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [logic [23:0]];

  function automatic logic [15:0] mem_rd(input logic [23:0] k);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  // SDRAM model: prog_dok one cycle before prog_rdy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_cnt        <= 0;
      bus.prog_dok  <= 1'b0;
      bus.prog_rdy  <= 1'b0;
      bus.prog_data <= 16'h0000;
    end else begin
      bus.prog_dok <= 1'b0;
      bus.prog_rdy <= 1'b0;
      if (bus.prog_rd && !bus.prog_rdy && sd_en) begin
        sd_cnt <= sd_cnt + 1;
        if (sd_cnt == LAT - 2) begin
          bus.prog_dok  <= 1'b1;
          bus.prog_data <= mem_rd({bus.prog_ba, bus.prog_addr});
        end
        if (sd_cnt == LAT - 1) begin
          bus.prog_rdy <= 1'b1;
          sd_cnt       <= 0;
        end
      end else begin
        sd_cnt <= 0;
      end
    end
  end

  // Count prog_rd accesses, their length, and ioctl_rdy pulses.
  int          prd_cnt = 0, rdy_cnt = 0, cur_len = 0, last_len = 0;
  logic        prd_l = 1'b0;
  logic [1:0]  cap_ba = '0;
  logic [21:0] cap_wa = '0;
  always @(negedge clk) begin
    if (bus.prog_rd && !prd_l) begin
      prd_cnt <= prd_cnt + 1;
      cap_ba  <= bus.prog_ba;
      cap_wa  <= bus.prog_addr;
      cur_len <= 1;
    end else if (bus.prog_rd) begin
      cur_len <= cur_len + 1;
    end
    if (!bus.prog_rd && prd_l) last_len <= cur_len;
    prd_l <= bus.prog_rd;
    if (bus.ioctl_rdy) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One host read; lat is strobe-to-ioctl_rdy in cycles, -1 if it never came.
  task automatic do_read(input logic [25:0] a, output logic [7:0] d, output int lat);
    @(negedge clk);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    lat = 1;
    d   = 8'h00;
    while (!bus.ioctl_rdy && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (bus.ioctl_rdy) d = bus.ioctl_din;
    else lat = -1;
  endtask

  task automatic ram_pulse();
    @(negedge clk) bus.ioctl_ram = 1'b0;
    @(negedge clk) bus.ioctl_ram = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [25:0] addr;
    logic [7:0]  dat;
    int          kind;   // 0 miss, 1 buffer hit, 2 out of range
    logic [1:0]  ba;
    logic [21:0] wa;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [7:0]  d;
    int          lat, p0, r0, miss;
    logic [15:0] lf;

    vt[0]  = '{26'h000_0000, 8'h5A, 0, 2'd0, 22'h00_0000};
    vt[1]  = '{26'h000_0001, 8'hA5, 1, 2'd0, 22'h00_0000};
    vt[2]  = '{26'h080_0006, 8'h34, 0, 2'd2, 22'h00_0003};
    vt[3]  = '{26'h080_0007, 8'h12, 1, 2'd2, 22'h00_0003};
    vt[4]  = '{26'h3FF_FFFF, 8'hFF, 2, 2'd0, 22'h00_0000};
    vt[5]  = '{26'h0C0_0010, 8'hEF, 0, 2'd3, 22'h00_0008};
    vt[6]  = '{26'h07F_FFFF, 8'hC3, 0, 2'd1, 22'h1F_FFFF};
    vt[7]  = '{26'h03F_FFFF, 8'h77, 0, 2'd0, 22'h1F_FFFF};
    vt[8]  = '{26'h03F_FFFE, 8'h88, 1, 2'd0, 22'h1F_FFFF};
    vt[9]  = '{26'h000_0000, 8'h5A, 0, 2'd0, 22'h00_0000};
    vt[10] = '{26'h200_0000, 8'hFF, 2, 2'd0, 22'h00_0000};
    vt[11] = '{26'h0BF_FFFF, 8'h99, 0, 2'd2, 22'h1F_FFFF};

    mem[{2'd0, 22'h00_0000}] = 16'hA55A;
    mem[{2'd2, 22'h00_0003}] = 16'h1234;
    mem[{2'd3, 22'h00_0008}] = 16'hBEEF;
    mem[{2'd1, 22'h1F_FFFF}] = 16'hC33C;
    mem[{2'd0, 22'h1F_FFFF}] = 16'h7788;
    mem[{2'd2, 22'h1F_FFFF}] = 16'h9966;

    rst = 1'b1;
    sd_en = 1'b1;
    bus.ioctl_ram  = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_rd   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ioctl_din", 32'(bus.ioctl_din), 32'h00);
    chk("reset ioctl_rdy", 32'(bus.ioctl_rdy), 32'h0);
    chk("reset prog_rd", 32'(bus.prog_rd), 32'h0);
    chk("reset prog_addr", 32'(bus.prog_addr), 32'h0);
    chk("reset prog_ba", 32'(bus.prog_ba), 32'h0);
    chk("reset prog_dsn", 32'(bus.prog_dsn), 32'h0);
    chk("reset busy/err", 32'({busy, err}), 32'h0);
    rst = 1'b0;
    @(negedge clk) bus.ioctl_ram = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table of single reads.
    foreach (vt[i]) begin
      p0 = prd_cnt;
      do_read(vt[i].addr, d, lat);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d data", i), 32'(d), 32'(vt[i].dat));
      chk($sformatf("v%0d latency", i), 32'(lat), (vt[i].kind == 0) ? 32'(LAT + 2) : 32'd1);
      chk($sformatf("v%0d prog_rd count", i), 32'(prd_cnt - p0), (vt[i].kind == 0) ? 32'd1 : 32'd0);
      if (vt[i].kind == 0) begin
        chk($sformatf("v%0d prog_ba", i), 32'(cap_ba), 32'(vt[i].ba));
        chk($sformatf("v%0d prog_addr", i), 32'(cap_wa), 32'(vt[i].wa));
        chk($sformatf("v%0d prog_rd length", i), 32'(last_len), 32'(LAT + 1));
      end
      chk($sformatf("v%0d err", i), 32'(err), 32'h0);
    end

    // Timeout: SDRAM never answers.
    sd_en = 1'b0;
    do_read(26'h0C0_0100, d, lat);
    chk("timeout latency", 32'(lat), 32'd256);
    chk("timeout data", 32'(d), 32'hFF);
    chk("timeout err", 32'(err), 32'h1);
    chk("timeout prog_rd", 32'(bus.prog_rd), 32'h0);
    chk("timeout busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    chk("timeout prog_rd length", 32'(last_len), 32'd255);
    sd_en = 1'b1;

    // Session restart clears err and invalidates the buffer.
    ram_pulse();
    chk("err cleared", 32'(err), 32'h0);
    do_read(26'h000_0000, d, lat);
    chk("after timeout latency", 32'(lat), 32'(LAT + 2));
    ram_pulse();
    do_read(26'h000_0001, d, lat);
    chk("after restart latency", 32'(lat), 32'(LAT + 2));
    chk("after restart data", 32'(d), 32'hA5);

    // Second strobe lands on the prog_rdy cycle of a pending miss.
    repeat (2) @(negedge clk);
    r0 = rdy_cnt;
    p0 = prd_cnt;
    @(negedge clk);
    bus.ioctl_addr = 26'h0C0_0010;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk) bus.ioctl_rd = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.ioctl_addr = 26'h000_0000;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk) bus.ioctl_rd = 1'b0;
    chk("overlap rdy", 32'(bus.ioctl_rdy), 32'h1);
    chk("overlap data", 32'(bus.ioctl_din), 32'hEF);
    repeat (10) @(negedge clk);
    chk("overlap err", 32'(err), 32'h1);
    chk("overlap rdy count", 32'(rdy_cnt - r0), 32'd1);
    chk("overlap prog_rd count", 32'(prd_cnt - p0), 32'd1);
    ram_pulse();

    // Strobe without an upload session is ignored.
    r0 = rdy_cnt;
    p0 = prd_cnt;
    @(negedge clk);
    bus.ioctl_ram  = 1'b0;
    bus.ioctl_addr = 26'h0C0_0020;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk) bus.ioctl_rd = 1'b0;
    repeat (10) @(negedge clk);
    chk("no session rdy count", 32'(rdy_cnt - r0), 32'd0);
    chk("no session prog_rd count", 32'(prd_cnt - p0), 32'd0);
    @(negedge clk) bus.ioctl_ram = 1'b1;
    repeat (2) @(negedge clk);

    // Session ends while the SDRAM read is pending.
    r0 = rdy_cnt;
    p0 = prd_cnt;
    @(negedge clk);
    bus.ioctl_addr = 26'h0C0_0030;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    bus.ioctl_rd  = 1'b0;
    bus.ioctl_ram = 1'b0;
    repeat (15) @(negedge clk);
    chk("ram fall rdy count", 32'(rdy_cnt - r0), 32'd0);
    chk("ram fall prog_rd count", 32'(prd_cnt - p0), 32'd1);
    chk("ram fall prog_rd/busy", 32'({bus.prog_rd, busy}), 32'h0);
    @(negedge clk) bus.ioctl_ram = 1'b1;
    do_read(26'h0C0_0030, d, lat);
    chk("ram fall reread latency", 32'(lat), 32'(LAT + 2));
    chk("ram fall reread data", 32'(d), 32'h00);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    bus.ioctl_addr = 26'h0C0_0040;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk) bus.ioctl_rd = 1'b0;
    @(negedge clk);
    chk("pre-reset prog_rd", 32'(bus.prog_rd), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async reset prog_rd", 32'(bus.prog_rd), 32'h0);
    chk("async reset busy", 32'(busy), 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // Bulk upload of an LFSR-filled 4 KB region in bank 1.
    lf = 16'hACE1;
    for (int w = 0; w < 2048; w++) begin
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      mem[{2'd1, 22'(w)}] = lf;
    end
    p0 = prd_cnt;
    for (int b = 0; b < 4096; b++) begin
      logic [15:0] w16;
      logic [7:0]  eb;
      w16 = mem_rd({2'd1, 22'(b >> 1)});
      eb  = b[0] ? w16[15:8] : w16[7:0];
      do_read(26'h040_0000 + 26'(b), d, lat);
      chk($sformatf("bulk byte %0d", b), 32'(d), 32'(eb));
    end
    repeat (2) @(negedge clk);
    miss = prd_cnt - p0;
    chk("bulk misses", 32'(miss), 32'd2048);
    chk("bulk hit ratio x2", 32'((4096 - miss) * 2), 32'd4096);
    chk("bulk err", 32'(err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
